// File: rtl/fmrv32im_alu_pkg.sv
// Shared opcode encodings, FSM state type and helpers for the fmrv32im multi-cycle ALU.
// Optional feature macro used by the ALU: FMRV_ALU_MINMAX_EN (MIN/MAX/MINU/MAXU support).
package fmrv32im_alu_pkg;

  localparam int ALU_OP_W = 5;

  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD  = 5'd0;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB  = 5'd1;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLL  = 5'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLT  = 5'd3;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLTU = 5'd4;
  localparam logic [ALU_OP_W-1:0] ALU_OP_XOR  = 5'd5;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRL  = 5'd6;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRA  = 5'd7;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = 5'd8;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = 5'd9;
  localparam logic [ALU_OP_W-1:0] ALU_OP_EQ   = 5'd10;
  localparam logic [ALU_OP_W-1:0] ALU_OP_NE   = 5'd11;
  localparam logic [ALU_OP_W-1:0] ALU_OP_GE   = 5'd12;
  localparam logic [ALU_OP_W-1:0] ALU_OP_GEU  = 5'd13;
  localparam logic [ALU_OP_W-1:0] ALU_OP_MIN  = 5'd16;
  localparam logic [ALU_OP_W-1:0] ALU_OP_MAX  = 5'd17;
  localparam logic [ALU_OP_W-1:0] ALU_OP_MINU = 5'd18;
  localparam logic [ALU_OP_W-1:0] ALU_OP_MAXU = 5'd19;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } alu_state_e;

  function automatic logic is_shift_op(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_OP_SLL) || (op == ALU_OP_SRL) || (op == ALU_OP_SRA);
  endfunction

  function automatic int shamt_w(input int xlen);
    return $clog2(xlen);
  endfunction

endpackage

// File: rtl/fmrv32im_alu_shifter.sv
// Iterative shift datapath: shifts at most SHIFT_STEP bits per step, starting either from a
// freshly offered operand (load) or from the working register (advance).
module fmrv32im_alu_shifter
  import fmrv32im_alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 8,
  localparam int SW        = shamt_w(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            advance,
  input  logic [XLEN-1:0] load_a,
  input  logic [SW-1:0]   load_shamt,
  input  logic            load_left,
  input  logic            load_arith,
  output logic [XLEN-1:0] value,
  output logic            done
);

  localparam logic [SW:0] STEP = (SW+1)'(SHIFT_STEP);

  logic [XLEN-1:0] work;
  logic [SW-1:0]   rem;
  logic            left_q;
  logic            arith_q;

  logic [XLEN-1:0] src;
  logic [SW-1:0]   src_rem;
  logic            src_left;
  logic            src_arith;
  logic [SW:0]     step;
  logic [SW-1:0]   next_rem;

  // The step taken this cycle is min(remaining, SHIFT_STEP); done means nothing is left after it.
  always_comb begin
    src       = load ? load_a     : work;
    src_rem   = load ? load_shamt : rem;
    src_left  = load ? load_left  : left_q;
    src_arith = load ? load_arith : arith_q;
    step      = ({1'b0, src_rem} > STEP) ? STEP : {1'b0, src_rem};
    next_rem  = src_rem - step[SW-1:0];
    if (src_left) begin
      value = src << step;
    end else if (src_arith) begin
      value = $unsigned($signed(src) >>> step);
    end else begin
      value = src >> step;
    end
    done = (next_rem == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work    <= '0;
      rem     <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else if (load || advance) begin
      work <= value;
      rem  <= next_rem;
      if (load) begin
        left_q  <= load_left;
        arith_q <= load_arith;
      end
    end
  end

endmodule

// File: rtl/fmrv32im_alu_mc.sv
// Handshaked execute-stage ALU with iterative shifts and a registered, stall-holding output.
// Define FMRV_ALU_MINMAX_EN to build the MIN/MAX/MINU/MAXU operations; otherwise they are illegal.
module fmrv32im_alu_mc
  import fmrv32im_alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 8,
  parameter int TAG_W      = 5
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [ALU_OP_W-1:0] IN_OP,
  input  logic [XLEN-1:0]     IN_A,
  input  logic [XLEN-1:0]     IN_B,
  input  logic [TAG_W-1:0]    IN_TAG,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [XLEN-1:0]     OUT_RSLT,
  output logic [TAG_W-1:0]    OUT_TAG,
  output logic                OUT_ILLEGAL
);

  localparam int SW = shamt_w(XLEN);

  alu_state_e state, next_state;

  logic             out_valid;
  logic [XLEN-1:0]  out_rslt;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;
  logic [TAG_W-1:0] pend_tag;

  logic             out_free;
  logic             accept;
  logic             load_out;
  logic             shift_load;
  logic             shift_adv;
  logic [XLEN-1:0]  shift_value;
  logic             shift_done;
  logic             lt_s;
  logic             lt_u;
  logic [XLEN-1:0]  alu_rslt;
  logic             alu_illegal;
  logic [XLEN-1:0]  nxt_rslt;
  logic             nxt_illegal;
  logic [TAG_W-1:0] nxt_tag;

  assign out_free = !out_valid || OUT_READY;
  assign IN_READY = (state == ST_IDLE) && out_free;
  assign accept   = IN_VALID && IN_READY;
  assign lt_s     = $signed(IN_A) < $signed(IN_B);
  assign lt_u     = IN_A < IN_B;

  fmrv32im_alu_shifter #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shifter (
    .clk        (CLK),
    .rst        (RST),
    .load       (shift_load),
    .advance    (shift_adv),
    .load_a     (IN_A),
    .load_shamt (IN_B[SW-1:0]),
    .load_left  (IN_OP == ALU_OP_SLL),
    .load_arith (IN_OP == ALU_OP_SRA),
    .value      (shift_value),
    .done       (shift_done)
  );

  // Shift ops report the shifter's first step so short shifts complete at accept like any other op.
  always_comb begin
    alu_rslt    = '0;
    alu_illegal = 1'b0;
    case (IN_OP)
      ALU_OP_ADD:  alu_rslt = IN_A + IN_B;
      ALU_OP_SUB:  alu_rslt = IN_A - IN_B;
      ALU_OP_SLT:  alu_rslt = XLEN'(lt_s);
      ALU_OP_SLTU: alu_rslt = XLEN'(lt_u);
      ALU_OP_XOR:  alu_rslt = IN_A ^ IN_B;
      ALU_OP_OR:   alu_rslt = IN_A | IN_B;
      ALU_OP_AND:  alu_rslt = IN_A & IN_B;
      ALU_OP_EQ:   alu_rslt = XLEN'(IN_A == IN_B);
      ALU_OP_NE:   alu_rslt = XLEN'(IN_A != IN_B);
      ALU_OP_GE:   alu_rslt = XLEN'(!lt_s);
      ALU_OP_GEU:  alu_rslt = XLEN'(!lt_u);
      ALU_OP_SLL,
      ALU_OP_SRL,
      ALU_OP_SRA:  alu_rslt = shift_value;
`ifdef FMRV_ALU_MINMAX_EN
      ALU_OP_MIN:  alu_rslt = lt_s ? IN_A : IN_B;
      ALU_OP_MAX:  alu_rslt = lt_s ? IN_B : IN_A;
      ALU_OP_MINU: alu_rslt = lt_u ? IN_A : IN_B;
      ALU_OP_MAXU: alu_rslt = lt_u ? IN_B : IN_A;
`endif
      default:     alu_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A finished shift waits in SHIFT, holding its value, until the output register is free.
  always_comb begin
    next_state  = state;
    load_out    = 1'b0;
    shift_load  = 1'b0;
    shift_adv   = 1'b0;
    nxt_rslt    = alu_rslt;
    nxt_illegal = alu_illegal;
    nxt_tag     = IN_TAG;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_shift_op(IN_OP)) begin
            shift_load = 1'b1;
            if (shift_done) begin
              load_out = 1'b1;
            end else begin
              next_state = ST_SHIFT;
            end
          end else begin
            load_out = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        shift_adv   = 1'b1;
        nxt_rslt    = shift_value;
        nxt_illegal = 1'b0;
        nxt_tag     = pend_tag;
        if (shift_done && out_free) begin
          load_out   = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid   <= 1'b0;
      out_rslt    <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
      pend_tag    <= '0;
    end else begin
      if (accept) begin
        pend_tag <= IN_TAG;
      end
      if (load_out) begin
        out_valid   <= 1'b1;
        out_rslt    <= nxt_rslt;
        out_tag     <= nxt_tag;
        out_illegal <= nxt_illegal;
      end else if (OUT_READY) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign OUT_VALID   = out_valid;
  assign OUT_RSLT    = out_rslt;
  assign OUT_TAG     = out_tag;
  assign OUT_ILLEGAL = out_illegal;

endmodule

// File: tb/tb_fmrv32im_alu_mc.sv
// Self-checking bench for fmrv32im_alu_mc: directed vector table, multi-cycle corner sequences,
// and randomized traffic scored against a plain-arithmetic reference model.
module tb_fmrv32im_alu_mc;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [4:0]  IN_OP;
  logic [31:0] IN_A;
  logic [31:0] IN_B;
  logic [4:0]  IN_TAG;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_RSLT;
  logic [4:0]  OUT_TAG;
  logic        OUT_ILLEGAL;

  int testsRun  = 0;
  int failCount = 0;

  typedef struct {
    logic [31:0] rslt;
    logic        ill;
    logic [4:0]  tag;
  } exp_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rslt;
    logic        ill;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [0:NV-1];

  exp_t sbq[$];
  logic stalled = 1'b0;
  exp_t held;

  fmrv32im_alu_mc #(
    .XLEN       (32),
    .SHIFT_STEP (8),
    .TAG_W      (5)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .IN_VALID    (IN_VALID),
    .IN_READY    (IN_READY),
    .IN_OP       (IN_OP),
    .IN_A        (IN_A),
    .IN_B        (IN_B),
    .IN_TAG      (IN_TAG),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .OUT_RSLT    (OUT_RSLT),
    .OUT_TAG     (OUT_TAG),
    .OUT_ILLEGAL (OUT_ILLEGAL)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference behaviour straight from the opcode table.
  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] tag);
    exp_t e;
    int   sh;
    e.rslt = '0;
    e.ill  = 1'b0;
    e.tag  = tag;
    sh     = int'(b[4:0]);
    case (op)
      5'd0:  e.rslt = a + b;
      5'd1:  e.rslt = a - b;
      5'd2:  e.rslt = a << sh;
      5'd3:  e.rslt = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd4:  e.rslt = (a < b) ? 32'd1 : 32'd0;
      5'd5:  e.rslt = a ^ b;
      5'd6:  e.rslt = a >> sh;
      5'd7:  e.rslt = $unsigned($signed(a) >>> sh);
      5'd8:  e.rslt = a | b;
      5'd9:  e.rslt = a & b;
      5'd10: e.rslt = (a == b) ? 32'd1 : 32'd0;
      5'd11: e.rslt = (a != b) ? 32'd1 : 32'd0;
      5'd12: e.rslt = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      5'd13: e.rslt = (a >= b) ? 32'd1 : 32'd0;
`ifdef FMRV_ALU_MINMAX_EN
      5'd16: e.rslt = ($signed(a) <= $signed(b)) ? a : b;
      5'd17: e.rslt = ($signed(a) >= $signed(b)) ? a : b;
      5'd18: e.rslt = (a <= b) ? a : b;
      5'd19: e.rslt = (a >= b) ? a : b;
`endif
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic int expLatency(input logic [4:0] op, input logic [31:0] b);
    int lat;
    lat = 1;
    if (op == 5'd2 || op == 5'd6 || op == 5'd7) begin
      lat = (int'(b[4:0]) + 7) / 8;
      if (lat < 1) lat = 1;
    end
    return lat;
  endfunction

  // Scoreboard: samples just before each rising edge, when inputs and outputs are settled.
  always @(negedge CLK) begin
    #4;
    if (RST) begin
      sbq.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        checkOutput("hold_valid", 32'(OUT_VALID), 32'd1);
        checkOutput("hold_rslt", OUT_RSLT, held.rslt);
        checkOutput("hold_tag", 32'(OUT_TAG), 32'(held.tag));
        checkOutput("hold_ill", 32'(OUT_ILLEGAL), 32'(held.ill));
      end
      if (OUT_VALID && OUT_READY) begin
        checkOutput("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          exp_t e;
          e = sbq.pop_front();
          checkOutput("sb_rslt", OUT_RSLT, e.rslt);
          checkOutput("sb_ill", 32'(OUT_ILLEGAL), 32'(e.ill));
          checkOutput("sb_tag", 32'(OUT_TAG), 32'(e.tag));
        end
      end
      stalled   = OUT_VALID && !OUT_READY;
      held.rslt = OUT_RSLT;
      held.ill  = OUT_ILLEGAL;
      held.tag  = OUT_TAG;
      if (IN_VALID && IN_READY) begin
        sbq.push_back(model(IN_OP, IN_A, IN_B, IN_TAG));
      end
    end
  end

  // Call at a falling edge; returns at the falling edge right after the accepting rising edge.
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] tag);
    logic got;
    got      = 1'b0;
    IN_OP    = op;
    IN_A     = a;
    IN_B     = b;
    IN_TAG   = tag;
    IN_VALID = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #4;
      got = IN_READY;
      @(negedge CLK);
      if (got) break;
    end
    IN_VALID = 1'b0;
    if (!got) checkOutput("accept_timeout", 32'(got), 32'd1);
  endtask

  task automatic waitResult(output int waited);
    waited = 0;
    while (!OUT_VALID && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    if (!OUT_VALID) checkOutput("result_timeout", 32'(OUT_VALID), 32'd1);
  endtask

  initial begin
    int waited;
    vecs[0]  = '{5'd0,  32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b0};
    vecs[1]  = '{5'd1,  32'd5,        32'd7,        32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{5'd4,  32'd1,        32'hFFFFFFFF, 32'd1,        1'b0};
    vecs[3]  = '{5'd3,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b0};
    vecs[4]  = '{5'd12, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0};
    vecs[5]  = '{5'd13, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0};
    vecs[6]  = '{5'd10, 32'd7,        32'd7,        32'd1,        1'b0};
    vecs[7]  = '{5'd11, 32'd7,        32'd7,        32'd0,        1'b0};
    vecs[8]  = '{5'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0};
    vecs[9]  = '{5'd8,  32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0};
    vecs[10] = '{5'd9,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
    vecs[11] = '{5'd7,  32'h80000000, 32'd20,       32'hFFFFF800, 1'b0};
    vecs[12] = '{5'd2,  32'd1,        32'd0,        32'd1,        1'b0};
    vecs[13] = '{5'd6,  32'h80000000, 32'd31,       32'd1,        1'b0};
    vecs[14] = '{5'd2,  32'd3,        32'h25,       32'h60,       1'b0};
    vecs[15] = '{5'd7,  32'h7FFFFFF0, 32'd8,        32'h007FFFFF, 1'b0};
    vecs[16] = '{5'd2,  32'd1,        32'd9,        32'h200,      1'b0};
    vecs[17] = '{5'd25, 32'd1,        32'd2,        32'd0,        1'b1};
    vecs[18] = '{5'd14, 32'd1,        32'd2,        32'd0,        1'b1};
`ifdef FMRV_ALU_MINMAX_EN
    vecs[19] = '{5'd16, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFE, 1'b0};
    vecs[20] = '{5'd17, 32'hFFFFFFFE, 32'd3,        32'd3,        1'b0};
    vecs[21] = '{5'd18, 32'hFFFFFFFE, 32'd3,        32'd3,        1'b0};
    vecs[22] = '{5'd19, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFE, 1'b0};
`else
    vecs[19] = '{5'd16, 32'hFFFFFFFE, 32'd3,        32'd0,        1'b1};
    vecs[20] = '{5'd17, 32'hFFFFFFFE, 32'd3,        32'd0,        1'b1};
    vecs[21] = '{5'd18, 32'hFFFFFFFE, 32'd3,        32'd0,        1'b1};
    vecs[22] = '{5'd19, 32'hFFFFFFFE, 32'd3,        32'd0,        1'b1};
`endif

    RST       = 1'b1;
    IN_VALID  = 1'b0;
    IN_OP     = '0;
    IN_A      = '0;
    IN_B      = '0;
    IN_TAG    = '0;
    OUT_READY = 1'b1;
    repeat (3) @(negedge CLK);
    checkOutput("rst_valid", 32'(OUT_VALID), 32'd0);
    checkOutput("rst_rslt", OUT_RSLT, 32'd0);
    checkOutput("rst_tag", 32'(OUT_TAG), 32'd0);
    checkOutput("rst_ill", 32'(OUT_ILLEGAL), 32'd0);
    checkOutput("rst_in_ready", 32'(IN_READY), 32'd1);
    RST = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i));
      waitResult(waited);
      checkOutput($sformatf("vec%0d_latency", i), 32'(waited), 32'(expLatency(vecs[i].op, vecs[i].b) - 1));
      checkOutput($sformatf("vec%0d_rslt", i), OUT_RSLT, vecs[i].rslt);
      checkOutput($sformatf("vec%0d_tag", i), 32'(OUT_TAG), 32'(i));
      checkOutput($sformatf("vec%0d_ill", i), 32'(OUT_ILLEGAL), 32'(vecs[i].ill));
    end
    @(negedge CLK);

    // Back-to-back single-cycle ops.
    IN_OP = 5'd1; IN_A = 32'd5; IN_B = 32'd7; IN_TAG = 5'd1; IN_VALID = 1'b1;
    #4 checkOutput("b2b_ready0", 32'(IN_READY), 32'd1);
    @(negedge CLK);
    checkOutput("b2b_rslt0", OUT_RSLT, 32'hFFFFFFFE);
    IN_OP = 5'd4; IN_A = 32'd1; IN_B = 32'hFFFFFFFF; IN_TAG = 5'd2;
    #4 checkOutput("b2b_ready1", 32'(IN_READY), 32'd1);
    @(negedge CLK);
    IN_VALID = 1'b0;
    checkOutput("b2b_valid1", 32'(OUT_VALID), 32'd1);
    checkOutput("b2b_rslt1", OUT_RSLT, 32'd1);
    @(negedge CLK);

    // SRA by 20 occupies the unit for two extra cycles; shamt 0 completes immediately.
    applyStimulus(5'd7, 32'h80000000, 32'd20, 5'd2);
    checkOutput("sra_ready_c1", 32'(IN_READY), 32'd0);
    checkOutput("sra_valid_c1", 32'(OUT_VALID), 32'd0);
    @(negedge CLK);
    checkOutput("sra_ready_c2", 32'(IN_READY), 32'd0);
    @(negedge CLK);
    checkOutput("sra_valid", 32'(OUT_VALID), 32'd1);
    checkOutput("sra_rslt", OUT_RSLT, 32'hFFFFF800);
    checkOutput("sra_ready_done", 32'(IN_READY), 32'd1);
    applyStimulus(5'd2, 32'h00001234, 32'h20, 5'd3);
    checkOutput("sll0_valid", 32'(OUT_VALID), 32'd1);
    checkOutput("sll0_rslt", OUT_RSLT, 32'h00001234);
    @(negedge CLK);

    // Output stall blocks new work and holds the pending result.
    OUT_READY = 1'b0;
    applyStimulus(5'd0, 32'd10, 32'd20, 5'd7);
    IN_OP = 5'd5; IN_A = 32'hF0; IN_B = 32'h0F; IN_TAG = 5'd8; IN_VALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #4;
      checkOutput("stall_in_ready", 32'(IN_READY), 32'd0);
      checkOutput("stall_rslt", OUT_RSLT, 32'd30);
      checkOutput("stall_tag", 32'(OUT_TAG), 32'd7);
      @(negedge CLK);
    end
    OUT_READY = 1'b1;
    #4 checkOutput("release_in_ready", 32'(IN_READY), 32'd1);
    @(negedge CLK);
    IN_VALID = 1'b0;
    checkOutput("release_valid", 32'(OUT_VALID), 32'd1);
    checkOutput("release_rslt", OUT_RSLT, 32'hFF);
    checkOutput("release_tag", 32'(OUT_TAG), 32'd8);
    @(negedge CLK);

    // Long SRL finishing into a stalled consumer.
    OUT_READY = 1'b0;
    applyStimulus(5'd6, 32'h80000000, 32'd31, 5'd9);
    waitResult(waited);
    checkOutput("srl31_latency", 32'(waited), 32'd3);
    checkOutput("srl31_rslt", OUT_RSLT, 32'd1);
    repeat (2) begin
      @(negedge CLK);
      checkOutput("srl31_held_valid", 32'(OUT_VALID), 32'd1);
      checkOutput("srl31_held_rslt", OUT_RSLT, 32'd1);
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    checkOutput("srl31_consumed", 32'(OUT_VALID), 32'd0);

    // Reset in the middle of a shift drops the operation.
    applyStimulus(5'd7, 32'h80000000, 32'd20, 5'd4);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checkOutput("midrst_valid", 32'(OUT_VALID), 32'd0);
    checkOutput("midrst_in_ready", 32'(IN_READY), 32'd1);
    repeat (5) begin
      @(negedge CLK);
      checkOutput("midrst_no_stale", 32'(OUT_VALID), 32'd0);
    end

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 600; c++) begin
      IN_VALID  = ($urandom_range(0, 3) != 0);
      IN_OP     = 5'($urandom_range(0, 31));
      IN_A      = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      IN_B      = ($urandom_range(0, 7) == 0) ? IN_A : $urandom;
      IN_TAG    = 5'($urandom_range(0, 31));
      OUT_READY = ($urandom_range(0, 3) != 0);
      @(negedge CLK);
    end
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    for (int i = 0; i < 50 && (sbq.size() != 0 || OUT_VALID); i++) @(negedge CLK);
    checkOutput("drain_empty", 32'(sbq.size()), 32'd0);
    checkOutput("drain_valid", 32'(OUT_VALID), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
